// File: rtl/module_alu_seq.sv
// module_alu_seq: parametrised sequential ALU for the Mini-CPU.
// Opcode and sign-magnitude immediate are latched on DECODE; operands are
// applied on CALC. Single-cycle ops register their result one cycle after
// calc_start. MUL runs a shift-add loop for IMM_W cycles with busy high.
// Optional feature: define MODULE_ALU_SEQ_SAT_EN to saturate ADD/ADDI/SUB/SUBI
// on signed overflow instead of wrapping.
module module_alu_seq #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [2:0]       opcode,
    input  logic             sinalImm,
    input  logic [IMM_W-1:0] imm,
    input  logic             calc_start,
    input  logic [WIDTH-1:0] v1,
    input  logic [WIDTH-1:0] v2,
    output logic [WIDTH-1:0] result,
    output logic             decoded,
    output logic             calculated,
    output logic             busy,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = (IMM_W > 1) ? $clog2(IMM_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMM_W - 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_MULT  = 2'd2
    } state_t;

    // Registered state
    state_t             r_state;
    op_t                r_op;
    logic               r_sgn;
    logic [IMM_W-1:0]   r_imm;
    logic [WIDTH-1:0]   r_result;
    logic               r_decoded;
    logic               r_calculated;
    logic               r_busy;
    logic               r_z;
    logic               r_n;
    logic               r_v;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [IMM_W-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    // Next-state values
    state_t             w_state_nxt;
    op_t                w_op_nxt;
    logic               w_sgn_nxt;
    logic [IMM_W-1:0]   w_imm_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_decoded_nxt;
    logic               w_calculated_nxt;
    logic               w_busy_nxt;
    logic               w_z_nxt;
    logic               w_n_nxt;
    logic               w_v_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [IMM_W-1:0]   w_mplier_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // Datapath
    logic [WIDTH-1:0]   w_imm_z;
    logic [WIDTH-1:0]   w_simm;
    logic               w_sub;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH-1:0]   w_sum;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_arith;
    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_upd;
    logic [WIDTH-1:0]   w_val;
    logic               w_vflag;

    assign result     = r_result;
    assign decoded    = r_decoded;
    assign calculated = r_calculated;
    assign busy       = r_busy;
    assign flag_z     = r_z;
    assign flag_n     = r_n;
    assign flag_v     = r_v;

    // Arithmetic: signed immediate, add/sub with overflow, one shift-add step
    always_comb begin
        w_imm_z = {{(WIDTH-IMM_W){1'b0}}, r_imm};
        w_simm  = r_sgn ? (~w_imm_z + WIDTH'(1)) : w_imm_z;
        w_sub   = (r_op == OP_SUB) || (r_op == OP_SUBI);
        w_opb   = ((r_op == OP_ADD) || (r_op == OP_SUB)) ? v2 : w_simm;
        w_sum   = w_sub ? (v1 - w_opb) : (v1 + w_opb);
        // add: operand signs equal; sub: operand signs differ; and result sign flipped
        w_ovf   = ((v1[MSB] ^ w_opb[MSB]) == w_sub) && (w_sum[MSB] != v1[MSB]);
`ifdef MODULE_ALU_SEQ_SAT_EN
        // overflow always lands on the side of v1's sign
        w_arith = w_ovf ? (v1[MSB] ? SMIN : SMAX) : w_sum;
`else
        w_arith = w_sum;
`endif
        w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
        // sign applied once at the end: v1*(-m) == -(v1*m) mod 2^WIDTH
        w_mul_res  = r_sgn ? (~w_acc_step + WIDTH'(1)) : w_acc_step;
    end

    // Next-state and output decode for the IDLE/READY/MULT controller
    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_sgn_nxt        = r_sgn;
        w_imm_nxt        = r_imm;
        w_result_nxt     = r_result;
        w_decoded_nxt    = 1'b0;
        w_calculated_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_z_nxt          = r_z;
        w_n_nxt          = r_n;
        w_v_nxt          = r_v;
        w_acc_nxt        = r_acc;
        w_mcand_nxt      = r_mcand;
        w_mplier_nxt     = r_mplier;
        w_cnt_nxt        = r_cnt;
        w_upd            = 1'b0;
        w_val            = '0;
        w_vflag          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (dec_valid) begin
                    w_op_nxt      = op_t'(opcode);
                    w_sgn_nxt     = sinalImm;
                    w_imm_nxt     = imm;
                    w_decoded_nxt = 1'b1;
                    w_state_nxt   = S_READY;
                end
            end
            S_READY: begin
                if (calc_start) begin
                    if (r_op == OP_MUL) begin
                        w_acc_nxt    = '0;
                        w_mcand_nxt  = v1;
                        w_mplier_nxt = r_imm;
                        w_cnt_nxt    = '0;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = S_MULT;
                    end else begin
                        w_calculated_nxt = 1'b1;
                        w_state_nxt      = S_IDLE;
                        case (r_op)
                            OP_LOAD: begin
                                w_upd = 1'b1;
                                w_val = w_simm;
                            end
                            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                                w_upd   = 1'b1;
                                w_val   = w_arith;
                                w_vflag = w_ovf;
                            end
                            OP_CLEAR: begin
                                w_upd = 1'b1;
                                w_val = '0;
                            end
                            default: w_upd = 1'b0;  // DISPLAY holds result and flags
                        endcase
                    end
                end else if (dec_valid) begin
                    w_op_nxt      = op_t'(opcode);
                    w_sgn_nxt     = sinalImm;
                    w_imm_nxt     = imm;
                    w_decoded_nxt = 1'b1;
                end
            end
            S_MULT: begin
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                w_busy_nxt   = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_busy_nxt       = 1'b0;
                    w_calculated_nxt = 1'b1;
                    w_upd            = 1'b1;
                    w_val            = w_mul_res;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_upd) begin
            w_result_nxt = w_val;
            w_z_nxt      = (w_val == '0);
            w_n_nxt      = w_val[MSB];
            w_v_nxt      = w_vflag;
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LOAD;
            r_sgn        <= 1'b0;
            r_imm        <= '0;
            r_result     <= '0;
            r_decoded    <= 1'b0;
            r_calculated <= 1'b0;
            r_busy       <= 1'b0;
            r_z          <= 1'b0;
            r_n          <= 1'b0;
            r_v          <= 1'b0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_sgn        <= w_sgn_nxt;
            r_imm        <= w_imm_nxt;
            r_result     <= w_result_nxt;
            r_decoded    <= w_decoded_nxt;
            r_calculated <= w_calculated_nxt;
            r_busy       <= w_busy_nxt;
            r_z          <= w_z_nxt;
            r_n          <= w_n_nxt;
            r_v          <= w_v_nxt;
            r_acc        <= w_acc_nxt;
            r_mcand      <= w_mcand_nxt;
            r_mplier     <= w_mplier_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

endmodule
